time_counter: RTL and testbench

//   Time-of-day counter for the clock display path: keeps hours, minutes and seconds as

---
 rtl/time_counter.sv | 151 +++++++++++++++
 tb/tb_time_counter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Time-of-day counter: binary hours/minutes/seconds advanced by a prescaled
// 1 s tick, with a button-driven set mode (hour, then minute) and a display
// blink flag derived from the prescaler phase while a field is being set.
module time_counter #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run_en,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [5:0] hour,
   output logic       sec_tick,
   output logic [1:0] state,
   output logic       blink
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } state_t;

   // Button index 0 = mode, 1 = inc
   logic [1:0] btn_raw;
   logic [1:0] sync1_reg;
   logic [1:0] sync2_reg;
   logic [1:0] prev_reg;
   logic [1:0] btn_edge;

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [5:0]    sec_reg, sec_next;
   logic [5:0]    min_reg, min_next;
   logic [5:0]    hour_reg, hour_next;
   logic          tick_reg, tick_next;
   logic          blink_reg, blink_next;

   assign btn_raw = {btn_inc, btn_mode};

   // Two-flop synchronizer plus previous-value flop; rising edge is a one-cycle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
      end else begin
         sync1_reg <= btn_raw;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   assign btn_edge = sync2_reg & ~prev_reg;

   // Next-state logic: prescaler, time fields with same-edge carries, set-mode FSM
   always_comb begin
      state_next = state_reg;
      presc_next = presc_reg;
      sec_next   = sec_reg;
      min_next   = min_reg;
      hour_next  = hour_reg;
      tick_next  = 1'b0;

      // Prescaler runs whenever not paused in RUN; set states always count for blink timing
      if (state_reg != RUN || run_en) begin
         presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + PRESC_ONE;
      end

      case (state_reg)
         RUN: begin
            // A mode edge takes priority over a coinciding second advance
            if (btn_edge[0]) begin
               state_next = SET_HR;
            end else if (run_en && presc_reg == PRESC_LAST) begin
               tick_next = 1'b1;
               if (sec_reg == 6'd59) begin
                  sec_next = '0;
                  if (min_reg == 6'd59) begin
                     min_next  = '0;
                     hour_next = (hour_reg == 6'd23) ? '0 : hour_reg + 6'd1;
                  end else begin
                     min_next = min_reg + 6'd1;
                  end
               end else begin
                  sec_next = sec_reg + 6'd1;
               end
            end
         end
         SET_HR: begin
            if (btn_edge[0]) begin
               state_next = SET_MIN;
            end else if (btn_edge[1]) begin
               hour_next = (hour_reg == 6'd23) ? '0 : hour_reg + 6'd1;
            end
         end
         SET_MIN: begin
            if (btn_edge[0]) begin
               // Restart the second cleanly so the first tick is a full period away
               state_next = RUN;
               sec_next   = '0;
               presc_next = '0;
            end else if (btn_edge[1]) begin
               min_next = (min_reg == 6'd59) ? '0 : min_reg + 6'd1;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase

      // Registered blink tracks the state and prescaler values being loaded this edge
      blink_next = (state_next != RUN) && (presc_next < PRESC_HALF);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         presc_reg <= '0;
         sec_reg   <= '0;
         min_reg   <= '0;
         hour_reg  <= '0;
         tick_reg  <= 1'b0;
         blink_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         presc_reg <= presc_next;
         sec_reg   <= sec_next;
         min_reg   <= min_next;
         hour_reg  <= hour_next;
         tick_reg  <= tick_next;
         blink_reg <= blink_next;
      end
   end

   assign sec      = sec_reg;
   assign min      = min_reg;
   assign hour     = hour_reg;
   assign sec_tick = tick_reg;
   assign state    = state_reg;
   assign blink    = blink_reg;

endmodule

// File: tb/tb_time_counter.sv
// Testbench for time_counter with TICK_DIV=4. The reference model keeps the
// time of day as a count of seconds since midnight plus a phase within the
// second, and reconstructs button edges from the sampled input history.
module tb_time_counter;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       run_en = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] sec, min, hour;
   logic       sec_tick;
   logic [1:0] state;
   logic       blink;
   logic [21:0] act;

   bit clk_run = 1'b1;
   int vectors = 0;
   int errors  = 0;

   // Reference model state
   int m_tod;
   int m_ph;
   int m_st;
   bit m_tick;
   bit mh1, mh2, mh3, ih1, ih2, ih3;

   time_counter #(.TICK_DIV(DIV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_en   (run_en),
      .btn_mode (btn_mode),
      .btn_inc  (btn_inc),
      .sec      (sec),
      .min      (min),
      .hour     (hour),
      .sec_tick (sec_tick),
      .state    (state),
      .blink    (blink)
   );

   assign act = {sec, min, hour, sec_tick, state, blink};

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_tod = 0; m_ph = 0; m_st = 0; m_tick = 1'b0;
      mh1 = 0; mh2 = 0; mh3 = 0; ih1 = 0; ih2 = 0; ih3 = 0;
   endfunction

   function automatic void model_step(input bit run, input bit bm, input bit bi);
      bit me, ie;
      int m;
      me = mh2 & ~mh3;
      ie = ih2 & ~ih3;
      mh3 = mh2; mh2 = mh1; mh1 = bm;
      ih3 = ih2; ih2 = ih1; ih1 = bi;
      m_tick = 1'b0;
      if (m_st == 0) begin
         if (me) begin
            m_st = 1;
            if (run) m_ph = (m_ph + 1) % DIV;
         end else if (run) begin
            if (m_ph == DIV - 1) begin
               m_ph = 0;
               m_tick = 1'b1;
               m_tod = (m_tod + 1) % 86400;
            end else begin
               m_ph = m_ph + 1;
            end
         end
      end else if (m_st == 1) begin
         m_ph = (m_ph + 1) % DIV;
         if (me) m_st = 2;
         else if (ie) m_tod = ((m_tod / 3600 + 1) % 24) * 3600 + m_tod % 3600;
      end else begin
         if (me) begin
            m_st = 0;
            m_ph = 0;
            m_tod = m_tod - m_tod % 60;
         end else begin
            m_ph = (m_ph + 1) % DIV;
            if (ie) begin
               m = (m_tod / 60) % 60;
               m_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
            end
         end
      end
   endfunction

   function automatic logic [21:0] expv();
      logic [5:0] s, mi, h;
      logic [1:0] st;
      logic bl;
      s  = 6'(m_tod % 60);
      mi = 6'((m_tod / 60) % 60);
      h  = 6'(m_tod / 3600);
      st = 2'(m_st);
      bl = (m_st != 0) && (m_ph < DIV / 2);
      return {s, mi, h, m_tick, st, bl};
   endfunction

   // One clock cycle for DUT and model; returns just after the falling edge
   task automatic cyc();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step(run_en, btn_mode, btn_inc);
      @(negedge clk);
   endtask

   // Press a button n times (2 cycles high, 3 low); the action lands inside each press
   task automatic press(input bit is_mode, input int n);
      repeat (n) begin
         if (is_mode) btn_mode = 1'b1;
         else btn_inc = 1'b1;
         cyc(); cyc();
         btn_mode = 1'b0;
         btn_inc = 1'b0;
         cyc(); cyc(); cyc();
      end
   endtask

   task automatic test_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (act !== 22'd0) begin
         errors++;
         $display("FAIL reset_async: got %h expected %h", act, 22'd0);
      end
      repeat (3) begin
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", act, expv());
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_run_wrap();
      run_en = 1'b1;
      for (int i = 0; i < 240; i++) begin
         cyc();
         vectors++;
         if (act !== expv() || sec_tick !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL run_wrap edge %0d: got %h tick %b expected %h tick %b",
                     i + 1, act, sec_tick, expv(), (i % 4 == 3));
         end
         if (i == 239) begin
            vectors++;
            if ({min, sec} !== {6'd1, 6'd0}) begin
               errors++;
               $display("FAIL run_wrap_min: got min %0d sec %0d expected min 1 sec 0", min, sec);
            end
         end
      end
   endtask

   task automatic test_set_rollover();
      int ticks;
      run_en = 1'b0;
      press(1'b1, 1);
      press(1'b0, (23 - m_tod / 3600 + 24) % 24);
      press(1'b1, 1);
      press(1'b0, (59 - (m_tod / 60) % 60 + 60) % 60);
      press(1'b1, 1);
      vectors++;
      if ({hour, min, sec, state} !== {6'd23, 6'd59, 6'd0, 2'd0}) begin
         errors++;
         $display("FAIL set_23_59: got h %0d m %0d s %0d st %0d expected 23 59 0 0",
                  hour, min, sec, state);
      end
      run_en = 1'b1;
      ticks = 0;
      for (int i = 0; i < 300 && ticks < 60; i++) begin
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL rollover_run: got %h expected %h", act, expv());
         end
         if (sec_tick === 1'b1) begin
            ticks++;
            if (ticks == 60) begin
               vectors++;
               if ({hour, min, sec} !== 18'd0) begin
                  errors++;
                  $display("FAIL day_rollover: got h %0d m %0d s %0d expected 0 0 0", hour, min, sec);
               end
            end
         end
      end
      vectors++;
      if (ticks != 60) begin
         errors++;
         $display("FAIL rollover_ticks: got %0d ticks expected 60", ticks);
      end
   endtask

   task automatic test_mode_freeze();
      int n;
      run_en = 1'b1;
      for (int i = 0; i < 400 && sec !== 6'd37; i++) begin
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL seek_37: got %h expected %h", act, expv());
         end
      end
      run_en = 1'b0;
      press(1'b1, 1);
      vectors++;
      if ({state, sec, sec_tick} !== {2'd1, 6'd37, 1'b0}) begin
         errors++;
         $display("FAIL freeze_enter: got st %0d sec %0d tick %b expected 1 37 0", state, sec, sec_tick);
      end
      run_en = 1'b1;
      repeat (8) begin
         cyc();
         vectors++;
         if (act !== expv() || sec !== 6'd37 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL freeze_hold: got %h expected %h", act, expv());
         end
      end
      press(1'b1, 1);
      btn_mode = 1'b1;
      n = 0;
      while (state !== 2'd0 && n < 6) begin
         cyc();
         n++;
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL return_run: got %h expected %h", act, expv());
         end
      end
      btn_mode = 1'b0;
      vectors++;
      if (state !== 2'd0 || sec !== 6'd0) begin
         errors++;
         $display("FAIL return_clear: got st %0d sec %0d expected 0 0", state, sec);
      end
      n = 0;
      do begin
         cyc();
         n++;
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL first_tick_run: got %h expected %h", act, expv());
         end
      end while (sec_tick !== 1'b1 && n < 10);
      vectors++;
      if (n != DIV) begin
         errors++;
         $display("FAIL first_tick_delay: got %0d cycles expected %0d", n, DIV);
      end
   endtask

   task automatic test_field_wrap();
      logic [5:0] sec_before;
      run_en = 1'b0;
      press(1'b1, 1);
      press(1'b0, (5 - m_tod / 3600 + 24) % 24);
      press(1'b1, 1);
      press(1'b0, (59 - (m_tod / 60) % 60 + 60) % 60);
      sec_before = sec;
      vectors++;
      if ({hour, min, state} !== {6'd5, 6'd59, 2'd2}) begin
         errors++;
         $display("FAIL setup_5_59: got h %0d m %0d st %0d expected 5 59 2", hour, min, state);
      end
      press(1'b0, 1);
      vectors++;
      if ({hour, min, sec} !== {6'd5, 6'd0, sec_before} || act !== expv()) begin
         errors++;
         $display("FAIL min_wrap: got h %0d m %0d s %0d expected 5 0 %0d", hour, min, sec, sec_before);
      end
      press(1'b1, 2);
      press(1'b0, 18);
      vectors++;
      if ({hour, state} !== {6'd23, 2'd1}) begin
         errors++;
         $display("FAIL setup_23: got h %0d st %0d expected 23 1", hour, state);
      end
      press(1'b0, 1);
      vectors++;
      if (hour !== 6'd0 || act !== expv()) begin
         errors++;
         $display("FAIL hour_wrap: got h %0d expected 0", hour);
      end
   endtask

   task automatic test_simultaneous();
      press(1'b0, 7);
      btn_mode = 1'b1;
      btn_inc = 1'b1;
      cyc(); cyc();
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      cyc(); cyc(); cyc();
      vectors++;
      if ({state, hour} !== {2'd2, 6'd7} || act !== expv()) begin
         errors++;
         $display("FAIL mode_wins: got st %0d h %0d expected 2 7", state, hour);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(7) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(3) == 0) btn_inc = ~btn_inc;
         if ($urandom_range(15) == 0) run_en = ~run_en;
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL random cyc %0d: got %h expected %h", i, act, expv());
         end
      end
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      repeat (4) cyc();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3 && state !== 2'd0; i++) press(1'b1, 1);
      run_en = 1'b1;
      for (int i = 0; i < 300 && sec !== 6'd12; i++) begin
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL seek_12: got %h expected %h", act, expv());
         end
      end
      run_en = 1'b0;
      press(1'b1, 1);
      vectors++;
      if ({state, sec} !== {2'd1, 6'd12}) begin
         errors++;
         $display("FAIL setup_12: got st %0d sec %0d expected 1 12", state, sec);
      end
      clk_run = 1'b0;
      #20;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (act !== 22'd0) begin
         errors++;
         $display("FAIL async_reset: got %h expected %h", act, 22'd0);
      end
      #20;
      rst_n = 1'b1;
      clk_run = 1'b1;
      run_en = 1'b1;
      repeat (12) begin
         cyc();
         vectors++;
         if (act !== expv()) begin
            errors++;
            $display("FAIL after_reset: got %h expected %h", act, expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_wrap();
      test_set_rollover();
      test_mode_freeze();
      test_field_wrap();
      test_simultaneous();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
